// File: rtl/reg_bank_arbiter_pkg.sv
// Shared FSM encoding and default sizing for the round-robin register-bank arbiter.
package reg_bank_arbiter_pkg;

   localparam int unsigned DefN = 4;
   localparam int unsigned DefW = 8;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StGrant   = 2'd1,
      StRelease = 2'd2
   } state_e;

endpackage

// File: rtl/reg_bank_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from last+1 with wrap.
module rr_picker
   import reg_bank_arbiter_pkg::*;
#(
   parameter int unsigned N  = DefN,
   parameter int unsigned LW = $clog2(DefN)
) (
   input  logic [N-1:0]  req_i,
   input  logic [LW-1:0] last_i,
   output logic [LW-1:0] sel_o,
   output logic          valid_o
);

   int unsigned idx;

   always_comb begin
      sel_o   = '0;
      valid_o = 1'b0;
      idx     = 0;
      // Offset N revisits last itself, so a lone request from the last owner still wins.
      for (int unsigned k = 1; k <= N; k++) begin
         idx = (int'(last_i) + k) % N;
         if (!valid_o && req_i[idx]) begin
            valid_o = 1'b1;
            sel_o   = LW'(idx);
         end
      end
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a shared W-bit register.
module reg_bank_arbiter
   import reg_bank_arbiter_pkg::*;
#(
   parameter int unsigned N = DefN,
   parameter int unsigned W = DefW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       d,
   output logic [N-1:0]         gnt,
   output logic [W-1:0]         q,
   output logic [$clog2(N)-1:0] owner,
   output logic                 busy,
   output logic [7:0]           wr_count
);

   localparam int unsigned LW = $clog2(N);

   state_e         state_q;
   logic [N-1:0]   gnt_q;
   logic [LW-1:0]  sel_q;
   logic [LW-1:0]  last_q;
   logic [LW-1:0]  owner_q;
   logic [7:0]     wr_count_q;
   logic [LW-1:0]  pick_sel;
   logic           pick_valid;
   logic [W-1:0]   bank_q;
   logic [W-1:0]   bank_d;
   logic           bank_we;
   logic [N-1:0]   one_hot_base;

   assign one_hot_base = {{(N-1){1'b0}}, 1'b1};

   rr_picker #(
      .N  (N),
      .LW (LW)
   ) u_rr_picker (
      .req_i   (req),
      .last_i  (last_q),
      .sel_o   (pick_sel),
      .valid_o (pick_valid)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         gnt_q      <= '0;
         sel_q      <= '0;
         last_q     <= LW'(N - 1);
         owner_q    <= '0;
         wr_count_q <= 8'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pick_valid) begin
                  state_q <= StGrant;
                  sel_q   <= pick_sel;
                  gnt_q   <= one_hot_base << pick_sel;
               end else begin
                  gnt_q <= '0;
               end
            end
            // The write commits here even if req[sel] already dropped.
            StGrant: begin
               owner_q    <= sel_q;
               last_q     <= sel_q;
               wr_count_q <= wr_count_q + 8'd1;
               state_q    <= StRelease;
            end
            StRelease: begin
               if (!req[sel_q]) begin
                  gnt_q   <= '0;
                  state_q <= StIdle;
               end
            end
            default: begin
               gnt_q   <= '0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Shared register bank: loads only on the GRANT exit edge.
   assign bank_we = (state_q == StGrant);
   assign bank_d  = d[int'(sel_q)*W +: W];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bank_q <= '0;
      end else if (bank_we) begin
         bank_q <= bank_d;
      end
   end

   assign gnt      = gnt_q;
   assign q        = bank_q;
   assign owner    = owner_q;
   assign busy     = (state_q != StIdle);
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter with hand-computed expectations.
module tb_reg_bank_arbiter;

   localparam int unsigned N = 4;
   localparam int unsigned W = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] d;
   logic [N-1:0]   gnt;
   logic [W-1:0]   q;
   logic [1:0]     owner;
   logic           busy;
   logic [7:0]     wr_count;

   int checks = 0;
   int errors = 0;

   reg_bank_arbiter #(
      .N (N),
      .W (W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .d        (d),
      .gnt      (gnt),
      .q        (q),
      .owner    (owner),
      .busy     (busy),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete single-requester handshake with checks at every phase.
   task automatic handshake(input int idx, input logic [7:0] data, input logic [7:0] exp_cnt);
      logic [N-1:0] exp_gnt;
      exp_gnt = 4'b0001 << idx;
      req = exp_gnt;
      d[idx*W +: W] = data;
      tick();
      check("hs_gnt", 32'(gnt), 32'(exp_gnt));
      check("hs_onehot", 32'($onehot0(gnt)), 32'd1);
      tick();
      check("hs_q", 32'(q), 32'(data));
      check("hs_cnt", 32'(wr_count), 32'(exp_cnt));
      req = '0;
      tick();
      check("hs_gnt_clr", 32'(gnt), 32'd0);
      check("hs_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0] rr_data [4];
      rr_data[0] = 8'h10;
      rr_data[1] = 8'h21;
      rr_data[2] = 8'h32;
      rr_data[3] = 8'h43;

      // Reset held two cycles with all requests asserted
      rst_n = 1'b0;
      req   = 4'b1111;
      d     = '0;
      tick();
      tick();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_q", 32'(q), 32'h00);
      check("rst_cnt", 32'(wr_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      rst_n = 1'b1;
      req   = '0;
      tick();
      check("idle_gnt", 32'(gnt), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      // Single write from requester 2
      req       = 4'b0100;
      d[23:16]  = 8'hA5;
      tick();
      check("sw_gnt", 32'(gnt), 32'b0100);
      check("sw_busy", 32'(busy), 32'd1);
      check("sw_q_hold", 32'(q), 32'h00);
      tick();
      check("sw_q", 32'(q), 32'hA5);
      check("sw_owner", 32'(owner), 32'd2);
      check("sw_cnt", 32'(wr_count), 32'd1);
      check("sw_gnt_held", 32'(gnt), 32'b0100);
      req = '0;
      tick();
      check("sw_gnt_clr", 32'(gnt), 32'd0);
      check("sw_busy_clr", 32'(busy), 32'd0);

      // Round-robin from fresh reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req   = 4'b1111;
      d     = {rr_data[3], rr_data[2], rr_data[1], rr_data[0]};
      for (int k = 0; k < 4; k++) begin
         tick();
         check("rr_gnt", 32'(gnt), 32'(4'b0001 << k));
         tick();
         check("rr_q", 32'(q), 32'(rr_data[k]));
         check("rr_owner", 32'(owner), 32'(k));
         req[k] = 1'b0;
         tick();
         check("rr_gnt_clr", 32'(gnt), 32'd0);
      end
      check("rr_cnt", 32'(wr_count), 32'd4);

      // Wrap-around from last = 3
      req     = 4'b1001;
      d[7:0]  = 8'h5A;
      d[31:24] = 8'hC3;
      tick();
      check("wrap_first", 32'(gnt), 32'b0001);
      tick();
      check("wrap_q0", 32'(q), 32'h5A);
      req[0] = 1'b0;
      tick();
      check("wrap_clr", 32'(gnt), 32'd0);
      tick();
      check("wrap_second", 32'(gnt), 32'b1000);
      tick();
      check("wrap_q3", 32'(q), 32'hC3);
      req = '0;
      tick();

      // Leave last = 0, then reset during GRANT of requester 1
      handshake(0, 8'h77, 8'd7);
      req     = 4'b0010;
      d[15:8] = 8'hFF;
      tick();
      check("mr_gnt", 32'(gnt), 32'b0010);
      rst_n = 1'b0;
      tick();
      check("mr_q", 32'(q), 32'h00);
      check("mr_gnt_clr", 32'(gnt), 32'd0);
      check("mr_cnt", 32'(wr_count), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      req   = 4'b0011;
      tick();
      check("mr_next_gnt", 32'(gnt), 32'b0001);
      req = '0;

      // Counter wrap over 256 handshakes
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 256; i++) begin
         handshake(i % 4, 8'(i), 8'((i + 1) % 256));
      end
      check("cnt_wrap", 32'(wr_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
